mest_pro_rom_arbiter: RTL and testbench
=======================================

// Module: mest_pro_rom_arbiter
// PURPOSE
//  Shares one synchronous instruction ROM (1-cycle read latency) between NUM_CORES mest_pro cores.
//  Arbitrates per-cycle fetch requests round-robin and issues at most one ROM read per cycle.
//  Returns the ROM word to the granted core with a one-hot valid.
//  Sits between the cores' o_req/o_prog_counter/i_instruction ports and the ROM macro.
// PARAMETERS
//  NUM_CORES        4    number of requesting cores (1..8)
//  ROM_DEPTH        256  ROM words; AW = $clog2(ROM_DEPTH)
//  INSTRUCTION_SIZE 28   ROM word width (4b opcode + 3x8b fields)
// PORTS
//  clk             in   1                     clock, all state on rising edge
//  i_reset         in   1                     synchronous reset, active-high
//  i_core_en       in   NUM_CORES             per-core enable; disabled cores are never granted
//  i_req           in   NUM_CORES             fetch request, level, one per core
//  i_prog_counter  in   NUM_CORES*AW          packed PCs, core k at [k*AW +: AW]
//  o_rom_req       out  1                     ROM read enable (combinational)
//  o_rom_addr      out  AW                    ROM address (combinational, PC of granted core)
//  i_rom_data      in   INSTRUCTION_SIZE      ROM data, valid the cycle after o_rom_req
//  o_instr_valid   out  NUM_CORES             one-hot, registered: o_instruction belongs to core k
//  o_instruction   out  INSTRUCTION_SIZE      broadcast instruction = i_rom_data when valid, else 0
//  o_grant_idx     out  $clog2(NUM_CORES)     index of core granted this cycle (0 when none)
//  o_busy          out  1                     read in flight (registered)
// BEHAVIOUR
//  - Reset: at the clk edge with i_reset=1: rr_ptr=0, issued_q=0, o_instr_valid=0, o_busy=0.
//    While i_reset=1: o_rom_req=0, o_rom_addr=0, o_grant_idx=0, o_instruction=0.
//  - Eligible(k) = i_req[k] & i_core_en[k] & ~issued_q[k].
//    issued_q = one-hot of the core granted the previous cycle.
//    Masking covers the cycle where the core still holds req while receiving its data.
//  - Arbitration (combinational): search from rr_ptr upward, modulo NUM_CORES.
//    The first eligible core is granted. o_rom_req=1, o_rom_addr=that core's PC, o_grant_idx=k.
//  - When no core is eligible: o_rom_req=0, o_rom_addr=0, o_grant_idx=0. rr_ptr and issued_q update as below (issued_q <= 0).
//  - On grant to k: rr_ptr <= (k+1) mod NUM_CORES (wraps NUM_CORES-1 -> 0), issued_q <= onehot(k).
//  - Latency: grant in cycle t -> o_instr_valid[k]=1 and o_instruction=i_rom_data in cycle t+1 (exactly 1 cycle).
//    o_busy = |issued_q.
//  - Throughput: one read per cycle. Back-to-back grants to different cores are allowed, i.e. a pipelined issue/return.
//  - Requester rule: hold i_req and PC stable until o_instr_valid[k].
//    req still high in the cycle after valid = new fetch. A core is granted at most every 2nd cycle.
//  - Fairness: a continuously eligible enabled core is granted within NUM_CORES cycles.
//  - i_core_en[k] dropped while k is in flight: the return still completes; no further grants.
//  - Request withdrawn before grant: dropped silently, no valid generated.
//  - Reset mid-operation: the in-flight return is discarded (o_instr_valid=0 the cycle after the reset edge).
//    Arbitration restarts from core 0.
//  - Only one valid bit per cycle; o_instruction is 0 when no valid is set.
// TESTING
//  1 Single core: req[0]=1, PC=0x05, ROM[5]=0xABCDEF1 ->
//    o_rom_addr=5 cycle t; o_instr_valid=0001, o_instruction=0xABCDEF1 at t+1.
//  2 Full contention: all 4 req held, en=1111, from reset ->
//    grants 0,1,2,3,0,1... one per cycle; valid one-hot follows 1 cycle later; no gaps.
//  3 Masking: only core 2 requests continuously ->
//    grants every other cycle (t, t+2, ...); never in the cycle its valid is high.
//  4 Enable mask: en=1010, all req high -> only cores 1 and 3 ever granted, alternating; cores 0/2 valid stays 0.
//  5 Wrap/fairness: rr_ptr=3, req=1001 -> core 3 granted, then core 0; core 0 waits at most NUM_CORES cycles.
//  6 Reset mid-op: grant core 1 in cycle t, i_reset=1 in cycle t ->
//    o_instr_valid=0 at t+1; after release, req=0011 grants core 0 first.

Source files
------------

// File: rtl/mest_pro_rom_arbiter_if.sv
// Fetch-side and ROM-side bus of the shared-ROM arbiter.
// The master modport is the environment (cores plus ROM macro). The slave modport is the arbiter.
interface mest_pro_rom_arbiter_if #(
    parameter int NUM_CORES        = 4,
    parameter int ROM_DEPTH        = 256,
    parameter int INSTRUCTION_SIZE = 28
);
    localparam int AW = $clog2(ROM_DEPTH);
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0]        i_core_en;
    logic [NUM_CORES-1:0]        i_req;
    logic [NUM_CORES*AW-1:0]     i_prog_counter;
    logic                        o_rom_req;
    logic [AW-1:0]               o_rom_addr;
    logic [INSTRUCTION_SIZE-1:0] i_rom_data;
    logic [NUM_CORES-1:0]        o_instr_valid;
    logic [INSTRUCTION_SIZE-1:0] o_instruction;
    logic [GW-1:0]               o_grant_idx;
    logic                        o_busy;

    modport master (
        output i_core_en, i_req, i_prog_counter, i_rom_data,
        input  o_rom_req, o_rom_addr, o_instr_valid, o_instruction, o_grant_idx, o_busy
    );

    modport slave (
        input  i_core_en, i_req, i_prog_counter, i_rom_data,
        output o_rom_req, o_rom_addr, o_instr_valid, o_instruction, o_grant_idx, o_busy
    );
endinterface

// File: rtl/mest_pro_rom_arbiter.sv
// Round-robin arbiter that lets NUM_CORES cores share one synchronous ROM with 1-cycle read latency.
// It issues at most one read per cycle and returns the word with a one-hot valid.
module mest_pro_rom_arbiter #(
    parameter int NUM_CORES        = 4,
    parameter int ROM_DEPTH        = 256,
    parameter int INSTRUCTION_SIZE = 28
) (
    input  logic                  clk,
    input  logic                  i_reset,
    mest_pro_rom_arbiter_if.slave bus
);
    localparam int AW = $clog2(ROM_DEPTH);
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [GW-1:0]        rr_ptr;
    logic [NUM_CORES-1:0] issued_q;
    logic [NUM_CORES-1:0] eligible;
    logic                 grant_any;
    logic [GW-1:0]        grant_idx;
    logic [GW-1:0]        next_ptr;
    logic                 rom_req;
    int                   idx;

    // A core whose read is still returning is masked, so a held request is not granted twice.
    assign eligible = bus.i_req & bus.i_core_en & ~issued_q;

    // NOTE: every variable gets a default before the search, so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = GW'(idx);
            end
        end
    end

    assign rom_req  = grant_any & ~i_reset;
    assign next_ptr = (grant_idx == GW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;

    assign bus.o_rom_req     = rom_req;
    assign bus.o_rom_addr    = rom_req ? bus.i_prog_counter[int'(grant_idx)*AW +: AW] : '0;
    assign bus.o_grant_idx   = rom_req ? grant_idx : '0;
    assign bus.o_instr_valid = issued_q;
    assign bus.o_busy        = |issued_q;
    assign bus.o_instruction = (|issued_q && !i_reset) ? bus.i_rom_data : '0;

    // NOTE: sequential state uses non-blocking assignments only, and reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            rr_ptr   <= '0;
            issued_q <= '0;
        end else if (grant_any) begin
            rr_ptr   <= next_ptr;
            issued_q <= NUM_CORES'(1) << grant_idx;
        end else begin
            issued_q <= '0;
        end
    end
endmodule

// File: tb/tb_mest_pro_rom_arbiter.sv
// Directed bench for mest_pro_rom_arbiter with a behavioural 1-cycle-latency ROM.
module tb_mest_pro_rom_arbiter;
    localparam int NC = 4;
    localparam int IW = 28;

    logic clk = 1'b0;
    logic i_reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [IW-1:0] rom [256];

    mest_pro_rom_arbiter_if #(.NUM_CORES(NC), .ROM_DEPTH(256), .INSTRUCTION_SIZE(IW)) bus ();

    mest_pro_rom_arbiter #(.NUM_CORES(NC), .ROM_DEPTH(256), .INSTRUCTION_SIZE(IW)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.o_rom_req) bus.i_rom_data <= rom[bus.o_rom_addr];
    end

    function automatic logic [IW-1:0] exp_ins(input int k);
        return 28'hC0DE000 + IW'(k);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset    = 1'b1;
        bus.i_req  = '0;
        step();
        i_reset    = 1'b0;
    endtask

    task automatic test_reset();
        i_reset            = 1'b1;
        bus.i_core_en      = 4'hF;
        bus.i_req          = 4'hF;
        bus.i_prog_counter = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        n_checks++; if (bus.o_rom_req !== 1'b0) begin n_fail++; $display("FAIL reset_rom_req: got %b want 0", bus.o_rom_req); end
        n_checks++; if (bus.o_rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 00", bus.o_rom_addr); end
        step();
        step();
        n_checks++; if (bus.o_instr_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", bus.o_instr_valid); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        n_checks++; if (bus.o_grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", bus.o_grant_idx); end
        n_checks++; if (bus.o_instruction !== 28'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.o_instruction); end
        bus.i_req = '0;
        i_reset   = 1'b0;
        step();
    endtask

    task automatic test_single_core();
        do_reset();
        bus.i_core_en      = 4'hF;
        bus.i_prog_counter = {8'h13, 8'h12, 8'h11, 8'h05};
        bus.i_req          = 4'b0001;
        #1;
        n_checks++; if (bus.o_rom_req !== 1'b1) begin n_fail++; $display("FAIL single_rom_req: got %b want 1", bus.o_rom_req); end
        n_checks++; if (bus.o_rom_addr !== 8'h05) begin n_fail++; $display("FAIL single_addr: got %h want 05", bus.o_rom_addr); end
        step();
        n_checks++; if (bus.o_instr_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b want 0001", bus.o_instr_valid); end
        n_checks++; if (bus.o_instruction !== 28'hABCDEF1) begin n_fail++; $display("FAIL single_instr: got %h want abcdef1", bus.o_instruction); end
        n_checks++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus.o_busy); end
        n_checks++; if (bus.o_rom_req !== 1'b0) begin n_fail++; $display("FAIL single_masked: got %b want 0", bus.o_rom_req); end
        bus.i_req = 4'b0000;
        step();
        n_checks++; if (bus.o_instr_valid !== 4'b0000) begin n_fail++; $display("FAIL single_idle_valid: got %b want 0000", bus.o_instr_valid); end
        n_checks++; if (bus.o_instruction !== 28'h0) begin n_fail++; $display("FAIL single_idle_instr: got %h want 0", bus.o_instruction); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_full_contention();
        do_reset();
        bus.i_core_en      = 4'hF;
        bus.i_prog_counter = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.i_req          = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_checks++; if (bus.o_grant_idx !== 2'(c % 4) || bus.o_rom_req !== 1'b1) begin n_fail++; $display("FAIL contention_grant c%0d: got %0d req %b want %0d req 1", c, bus.o_grant_idx, bus.o_rom_req, c % 4); end
            n_checks++; if (bus.o_rom_addr !== 8'(8'h10 + c % 4)) begin n_fail++; $display("FAIL contention_addr c%0d: got %h want %h", c, bus.o_rom_addr, 8'(8'h10 + c % 4)); end
            if (c > 0) begin
                n_checks++; if (bus.o_instr_valid !== 4'(1 << ((c - 1) % 4))) begin n_fail++; $display("FAIL contention_valid c%0d: got %b want %b", c, bus.o_instr_valid, 4'(1 << ((c - 1) % 4))); end
                n_checks++; if (bus.o_instruction !== exp_ins((c - 1) % 4)) begin n_fail++; $display("FAIL contention_instr c%0d: got %h want %h", c, bus.o_instruction, exp_ins((c - 1) % 4)); end
            end
            step();
        end
    endtask

    task automatic test_masking();
        do_reset();
        bus.i_core_en      = 4'hF;
        bus.i_prog_counter = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.i_req          = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++; if (bus.o_rom_req !== ((c % 2) == 0)) begin n_fail++; $display("FAIL mask_req c%0d: got %b want %b", c, bus.o_rom_req, (c % 2) == 0); end
            n_checks++; if (bus.o_instr_valid !== (((c % 2) == 1) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL mask_valid c%0d: got %b", c, bus.o_instr_valid); end
            if ((c % 2) == 0) begin
                n_checks++; if (bus.o_grant_idx !== 2'd2) begin n_fail++; $display("FAIL mask_grant c%0d: got %0d want 2", c, bus.o_grant_idx); end
            end
            step();
        end
    endtask

    task automatic test_enable_mask();
        do_reset();
        bus.i_core_en      = 4'b1010;
        bus.i_prog_counter = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.i_req          = 4'hF;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++; if (bus.o_grant_idx !== (((c % 2) == 0) ? 2'd1 : 2'd3)) begin n_fail++; $display("FAIL enmask_grant c%0d: got %0d", c, bus.o_grant_idx); end
            if (c > 0) begin
                n_checks++; if (bus.o_instr_valid !== (((c % 2) == 1) ? 4'b0010 : 4'b1000)) begin n_fail++; $display("FAIL enmask_valid c%0d: got %b", c, bus.o_instr_valid); end
            end
            step();
        end
        // Core 3 is in flight here; dropping its enable must not cancel the return.
        bus.i_core_en = 4'b0000;
        #1;
        n_checks++; if (bus.o_instr_valid !== 4'b1000 || bus.o_instruction !== exp_ins(3)) begin n_fail++; $display("FAIL endrop_return: got %b %h want 1000 %h", bus.o_instr_valid, bus.o_instruction, exp_ins(3)); end
        n_checks++; if (bus.o_rom_req !== 1'b0) begin n_fail++; $display("FAIL endrop_req: got %b want 0", bus.o_rom_req); end
        step();
        bus.i_core_en = 4'hF;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.i_core_en      = 4'hF;
        bus.i_prog_counter = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.i_req          = 4'b0100;
        #1;
        n_checks++; if (bus.o_grant_idx !== 2'd2) begin n_fail++; $display("FAIL wrap_setup: got %0d want 2", bus.o_grant_idx); end
        step();
        bus.i_req = 4'b1001;
        #1;
        n_checks++; if (bus.o_grant_idx !== 2'd3 || bus.o_rom_req !== 1'b1) begin n_fail++; $display("FAIL wrap_g3: got %0d req %b want 3 req 1", bus.o_grant_idx, bus.o_rom_req); end
        step();
        n_checks++; if (bus.o_grant_idx !== 2'd0 || bus.o_rom_req !== 1'b1) begin n_fail++; $display("FAIL wrap_g0: got %0d req %b want 0 req 1", bus.o_grant_idx, bus.o_rom_req); end
        n_checks++; if (bus.o_instr_valid !== 4'b1000) begin n_fail++; $display("FAIL wrap_v3: got %b want 1000", bus.o_instr_valid); end
        step();
        n_checks++; if (bus.o_grant_idx !== 2'd3) begin n_fail++; $display("FAIL wrap_g3b: got %0d want 3", bus.o_grant_idx); end
        n_checks++; if (bus.o_instr_valid !== 4'b0001 || bus.o_instruction !== exp_ins(0)) begin n_fail++; $display("FAIL wrap_v0: got %b %h want 0001 %h", bus.o_instr_valid, bus.o_instruction, exp_ins(0)); end
        step();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        bus.i_core_en      = 4'hF;
        bus.i_prog_counter = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.i_req          = 4'b0001;
        #1;
        n_checks++; if (bus.o_grant_idx !== 2'd0 || bus.o_rom_req !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %0d req %b want 0 req 1", bus.o_grant_idx, bus.o_rom_req); end
        step();
        bus.i_req = 4'b0010;
        i_reset   = 1'b1;
        #1;
        n_checks++; if (bus.o_rom_req !== 1'b0 || bus.o_grant_idx !== 2'd0 || bus.o_rom_addr !== 8'h00) begin n_fail++; $display("FAIL midrst_comb: got req %b idx %0d addr %h want 0 0 00", bus.o_rom_req, bus.o_grant_idx, bus.o_rom_addr); end
        n_checks++; if (bus.o_instruction !== 28'h0) begin n_fail++; $display("FAIL midrst_instr: got %h want 0", bus.o_instruction); end
        step();
        n_checks++; if (bus.o_instr_valid !== 4'b0000 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b busy %b want 0000 0", bus.o_instr_valid, bus.o_busy); end
        i_reset   = 1'b0;
        bus.i_req = 4'b0011;
        #1;
        n_checks++; if (bus.o_grant_idx !== 2'd0 || bus.o_rom_req !== 1'b1) begin n_fail++; $display("FAIL midrst_restart: got %0d req %b want 0 req 1", bus.o_grant_idx, bus.o_rom_req); end
        step();
        n_checks++; if (bus.o_grant_idx !== 2'd1 || bus.o_instr_valid !== 4'b0001) begin n_fail++; $display("FAIL midrst_next: got %0d %b want 1 0001", bus.o_grant_idx, bus.o_instr_valid); end
        bus.i_req = 4'b0000;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 28'h0100000 | IW'(i);
        rom[5] = 28'hABCDEF1;
        for (int k = 0; k < NC; k++) rom[8'h10 + k] = exp_ins(k);
        i_reset            = 1'b1;
        bus.i_core_en      = '0;
        bus.i_req          = '0;
        bus.i_prog_counter = '0;
        bus.i_rom_data     = '0;

        test_reset();
        test_single_core();
        test_full_contention();
        test_masking();
        test_enable_mask();
        test_wrap();
        test_reset_mid_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
